// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one burst memory port between icache refill and
// dcache refill/writeback; routes read beats to the owner and drives cpu_stall.
module mem_arbiter #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned BURST  = 4,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req_valid,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_req_ready,
  output logic              ic_resp_valid,
  output logic              ic_resp_last,
  input  logic              dc_req_valid,
  input  logic              dc_req_rnw,
  input  logic [ADDR_W-1:0] dc_req_addr,
  output logic              dc_req_ready,
  input  logic [DATA_W-1:0] dc_wdata,
  input  logic              dc_wdata_valid,
  output logic              dc_wdata_ready,
  output logic              dc_resp_valid,
  output logic              dc_resp_last,
  output logic [DATA_W-1:0] resp_data,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic              mem_cmd_rnw,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wdata_valid,
  input  logic              mem_wdata_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdata_valid,
  output logic              cpu_stall,
  output logic              proto_err
);

  localparam int unsigned CNT_W = $clog2(BURST);
  localparam int unsigned OFF_W = $clog2(BURST * DATA_W / 8);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    WDATA = 2'd2,
    RDATA = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              owner_dc;
  logic              last_dc;
  logic              rnw;
  logic [ADDR_W-1:0] addr;

  logic grant_any;
  logic grant_dc;
  logic last_beat;
  logic wbeat;
  logic rbeat;

  // Round robin: on a tie the requester that was not granted last wins.
  assign grant_any = ic_req_valid | dc_req_valid;
  assign grant_dc  = dc_req_valid & (~ic_req_valid | ~last_dc);
  assign last_beat = (cnt == CNT_W'(BURST - 1));
  assign wbeat     = (state == WDATA) & dc_wdata_valid & mem_wdata_ready;
  assign rbeat     = (state == RDATA) & mem_rdata_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      owner_dc  <= 1'b0;
      last_dc   <= 1'b1;
      rnw       <= 1'b0;
      addr      <= '0;
      proto_err <= 1'b0;
    end else begin
      if (mem_rdata_valid && (state != RDATA)) proto_err <= 1'b1;
      case (state)
        IDLE: begin
          if (grant_any) begin
            owner_dc <= grant_dc;
            last_dc  <= grant_dc;
            rnw      <= grant_dc ? dc_req_rnw : 1'b1;
            addr     <= grant_dc ? dc_req_addr : ic_req_addr;
            state    <= CMD;
          end
        end
        CMD: begin
          if (mem_cmd_ready) begin
            state <= rnw ? RDATA : WDATA;
            cnt   <= '0;
          end
        end
        WDATA: begin
          if (wbeat) begin
            cnt <= cnt + CNT_W'(1);
            if (last_beat) state <= IDLE;
          end
        end
        RDATA: begin
          if (rbeat) begin
            cnt <= cnt + CNT_W'(1);
            if (last_beat) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ic_req_ready = (state == IDLE) & grant_any & ~grant_dc;
  assign dc_req_ready = (state == IDLE) & grant_dc;

  assign mem_cmd_valid = (state == CMD);
  assign mem_cmd_rnw   = rnw;
  assign mem_cmd_addr  = addr & ~OFF_MASK;

  // Writeback beats flow straight through; the arbiter only counts them.
  assign mem_wdata       = (state == WDATA) ? dc_wdata : '0;
  assign mem_wdata_valid = (state == WDATA) & dc_wdata_valid;
  assign dc_wdata_ready  = (state == WDATA) & mem_wdata_ready;

  assign ic_resp_valid = rbeat & ~owner_dc;
  assign dc_resp_valid = rbeat & owner_dc;
  assign ic_resp_last  = rbeat & ~owner_dc & last_beat;
  assign dc_resp_last  = rbeat & owner_dc & last_beat;
  assign resp_data     = rbeat ? mem_rdata : '0;

  assign cpu_stall = ic_req_valid | dc_req_valid | (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expectations into queues,
// a negedge monitor pops and compares grants, commands, write and read beats.
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         ic_req_valid;
  logic [31:0]  ic_req_addr;
  logic         ic_req_ready;
  logic         ic_resp_valid;
  logic         ic_resp_last;
  logic         dc_req_valid;
  logic         dc_req_rnw;
  logic [31:0]  dc_req_addr;
  logic         dc_req_ready;
  logic [127:0] dc_wdata;
  logic         dc_wdata_valid;
  logic         dc_wdata_ready;
  logic         dc_resp_valid;
  logic         dc_resp_last;
  logic [127:0] resp_data;
  logic         mem_cmd_valid;
  logic         mem_cmd_ready;
  logic         mem_cmd_rnw;
  logic [31:0]  mem_cmd_addr;
  logic [127:0] mem_wdata;
  logic         mem_wdata_valid;
  logic         mem_wdata_ready;
  logic [127:0] mem_rdata;
  logic         mem_rdata_valid;
  logic         cpu_stall;
  logic         proto_err;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
    .ic_resp_valid(ic_resp_valid), .ic_resp_last(ic_resp_last),
    .dc_req_valid(dc_req_valid), .dc_req_rnw(dc_req_rnw), .dc_req_addr(dc_req_addr),
    .dc_req_ready(dc_req_ready), .dc_wdata(dc_wdata), .dc_wdata_valid(dc_wdata_valid),
    .dc_wdata_ready(dc_wdata_ready), .dc_resp_valid(dc_resp_valid), .dc_resp_last(dc_resp_last),
    .resp_data(resp_data), .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_rnw(mem_cmd_rnw), .mem_cmd_addr(mem_cmd_addr), .mem_wdata(mem_wdata),
    .mem_wdata_valid(mem_wdata_valid), .mem_wdata_ready(mem_wdata_ready),
    .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
    .cpu_stall(cpu_stall), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         dc;
    logic         last;
    logic [127:0] data;
  } resp_t;

  typedef struct packed {
    logic        rnw;
    logic [31:0] addr;
  } cmd_t;

  resp_t        resp_q[$];
  cmd_t         cmd_q[$];
  logic         grant_q[$];
  logic [127:0] wd_q[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h required=%0h", name, got, exp);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s: got an unexpected event, required none", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant();
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ic_req_ready || dc_req_ready) seen = 1'b1;
    end
    check("grant_timeout", seen, 1'b1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] bd(input int t, input int b);
    return 128'hA5A5_0000_0000_0000_0000_0000_0000_0000 | 128'(t * 16 + b);
  endfunction

  task automatic push_reads(input logic dc, input int t, input int n);
    for (int b = 0; b < n; b++) resp_q.push_back('{dc: dc, last: (b == 3), data: bd(t, b)});
  endtask

  task automatic rd_burst(input int t);
    for (int b = 0; b < 4; b++) begin
      mem_rdata       = bd(t, b);
      mem_rdata_valid = 1'b1;
      step();
    end
    mem_rdata_valid = 1'b0;
  endtask

  // Scoreboard monitor, sampling away from the rising edge.
  always @(negedge clk) begin : monitor
    resp_t er;
    cmd_t  ec;
    logic  eg;
    logic [127:0] ew;
    if (ic_req_ready || dc_req_ready) begin
      if (ic_req_ready && dc_req_ready) unexpected("dual_req_ready");
      else if (grant_q.size() == 0) unexpected("grant");
      else begin
        eg = grant_q.pop_front();
        check("grant_owner_dc", dc_req_ready, eg);
      end
    end
    if (mem_cmd_valid && mem_cmd_ready) begin
      if (cmd_q.size() == 0) unexpected("mem_cmd");
      else begin
        ec = cmd_q.pop_front();
        check("mem_cmd", {mem_cmd_rnw, mem_cmd_addr}, ec);
      end
    end
    if (mem_wdata_valid && mem_wdata_ready) begin
      if (wd_q.size() == 0) unexpected("mem_wdata");
      else begin
        ew = wd_q.pop_front();
        check("mem_wdata", mem_wdata, ew);
      end
    end
    if (ic_resp_valid || dc_resp_valid) begin
      if (ic_resp_valid && dc_resp_valid) unexpected("dual_resp_valid");
      else if (resp_q.size() == 0) unexpected("resp_beat");
      else begin
        er = resp_q.pop_front();
        check("resp_beat", {dc_resp_valid, ic_resp_last | dc_resp_last, resp_data}, er);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [127:0] wd[4];
    int i;
    int c;

    rst = 1'b1;
    ic_req_valid = 1'b0; ic_req_addr = '0;
    dc_req_valid = 1'b0; dc_req_rnw = 1'b0; dc_req_addr = '0;
    dc_wdata = '0; dc_wdata_valid = 1'b0;
    mem_cmd_ready = 1'b0; mem_wdata_ready = 1'b0;
    mem_rdata = '0; mem_rdata_valid = 1'b0;
    repeat (2) step();
    check("rst_cmd_valid", mem_cmd_valid, 1'b0);
    check("rst_cpu_stall", cpu_stall, 1'b0);
    check("rst_proto_err", proto_err, 1'b0);
    check("rst_cmd_addr", mem_cmd_addr, 32'h0);
    check("rst_cmd_rnw", mem_cmd_rnw, 1'b0);
    rst = 1'b0;
    step();

    // Single icache read, unaligned address.
    grant_q.push_back(1'b0);
    cmd_q.push_back('{rnw: 1'b1, addr: 32'h1000_0000});
    push_reads(1'b0, 1, 4);
    ic_req_addr = 32'h1000_0034;
    ic_req_valid = 1'b1;
    wait_grant();
    ic_req_valid = 1'b0;
    mem_cmd_ready = 1'b1;
    step();
    mem_cmd_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      mem_rdata = bd(1, b);
      mem_rdata_valid = 1'b1;
      @(negedge clk);
      check("ic_rd_stall_busy", cpu_stall, 1'b1);
      @(posedge clk);
      #1;
    end
    mem_rdata_valid = 1'b0;
    @(negedge clk);
    check("ic_rd_stall_after", cpu_stall, 1'b0);
    step();

    // Dcache writeback with write back-pressure on the second beat.
    for (int b = 0; b < 4; b++) begin
      wd[b] = 128'hBEEF_0000_0000_0000_0000_0000_0000_0000 | 128'(b);
      wd_q.push_back(wd[b]);
    end
    grant_q.push_back(1'b1);
    cmd_q.push_back('{rnw: 1'b0, addr: 32'h1000_0040});
    dc_req_rnw = 1'b0;
    dc_req_addr = 32'h1000_0040;
    dc_req_valid = 1'b1;
    wait_grant();
    dc_req_valid = 1'b0;
    mem_cmd_ready = 1'b1;
    step();
    mem_cmd_ready = 1'b0;
    i = 0;
    c = 0;
    while (i < 4 && c < 40) begin
      mem_wdata_ready = !(c >= 1 && c <= 3);
      dc_wdata = wd[i];
      dc_wdata_valid = 1'b1;
      @(negedge clk);
      check("wready_mirror", dc_wdata_ready, mem_wdata_ready);
      if (dc_wdata_ready) i++;
      c++;
      @(posedge clk);
      #1;
    end
    dc_wdata_valid = 1'b0;
    mem_wdata_ready = 1'b0;
    check("wr_cycles", c, 7);
    @(negedge clk);
    check("wr_idle_stall", cpu_stall, 1'b0);
    step();

    // Both requesters held: grants alternate starting with icache.
    dc_req_rnw = 1'b1;
    ic_req_addr = 32'h2000_0010;
    dc_req_addr = 32'h3000_00A8;
    ic_req_valid = 1'b1;
    dc_req_valid = 1'b1;
    for (int t = 10; t < 14; t++) begin
      grant_q.push_back(t[0]);
      cmd_q.push_back('{rnw: 1'b1, addr: t[0] ? 32'h3000_0080 : 32'h2000_0000});
      push_reads(t[0], t, 4);
      wait_grant();
      mem_cmd_ready = 1'b1;
      step();
      mem_cmd_ready = 1'b0;
      rd_burst(t);
    end
    ic_req_valid = 1'b0;
    dc_req_valid = 1'b0;
    step();

    // Dcache read with the command held off for five cycles.
    grant_q.push_back(1'b1);
    cmd_q.push_back('{rnw: 1'b1, addr: 32'h1000_0080});
    push_reads(1'b1, 20, 4);
    dc_req_rnw = 1'b1;
    dc_req_addr = 32'h1000_0080;
    dc_req_valid = 1'b1;
    wait_grant();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("cmd_hold_valid", mem_cmd_valid, 1'b1);
      check("cmd_hold_addr", mem_cmd_addr, 32'h1000_0080);
      check("cmd_hold_rnw", mem_cmd_rnw, 1'b1);
      check("cmd_hold_no_ready", dc_req_ready, 1'b0);
      @(posedge clk);
      #1;
    end
    dc_req_valid = 1'b0;
    mem_cmd_ready = 1'b1;
    step();
    mem_cmd_ready = 1'b0;
    rd_burst(20);
    step();

    // Reset mid-read after the first beat.
    grant_q.push_back(1'b0);
    cmd_q.push_back('{rnw: 1'b1, addr: 32'h1000_0100});
    resp_q.push_back('{dc: 1'b0, last: 1'b0, data: bd(30, 0)});
    ic_req_addr = 32'h1000_0100;
    ic_req_valid = 1'b1;
    wait_grant();
    ic_req_valid = 1'b0;
    mem_cmd_ready = 1'b1;
    step();
    mem_cmd_ready = 1'b0;
    mem_rdata = bd(30, 0);
    mem_rdata_valid = 1'b1;
    step();
    mem_rdata = bd(30, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_ic_resp", ic_resp_valid, 1'b0);
    check("mid_rst_dc_resp", dc_resp_valid, 1'b0);
    check("mid_rst_resp_data", resp_data, 128'h0);
    check("mid_rst_cpu_stall", cpu_stall, 1'b0);
    check("mid_rst_cmd_valid", mem_cmd_valid, 1'b0);
    check("mid_rst_proto_err", proto_err, 1'b0);
    step();
    rst = 1'b0;
    for (int b = 1; b < 4; b++) begin
      mem_rdata = bd(30, b);
      mem_rdata_valid = 1'b1;
      step();
    end
    mem_rdata_valid = 1'b0;
    check("abandon_proto_err", proto_err, 1'b1);
    step();

    // Stray read beat while idle.
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("stray_pre_proto_err", proto_err, 1'b0);
    mem_rdata = 128'hDEAD;
    mem_rdata_valid = 1'b1;
    @(negedge clk);
    check("stray_no_ic_resp", ic_resp_valid, 1'b0);
    check("stray_no_dc_resp", dc_resp_valid, 1'b0);
    @(posedge clk);
    #1;
    mem_rdata_valid = 1'b0;
    check("stray_proto_err", proto_err, 1'b1);
    repeat (5) step();
    check("stray_proto_sticky", proto_err, 1'b1);

    check("resp_q_drained", resp_q.size(), 0);
    check("cmd_q_drained", cmd_q.size(), 0);
    check("grant_q_drained", grant_q.size(), 0);
    check("wd_q_drained", wd_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
